fifo_rd_stream_hsst2ad: RTL and testbench

Read-side consumer of the hsst2ad parameterized FIFO. It converts the FIFO's rd_en/rd_data/rd_empty interface, with its fixed read latency, into a valid/ready stream with a packet-boundary marker. The stream feeds the AD sample path. Read requests are issued on credit into a small skid buffer, so downstream backpressure never loses in-flight words and there is no combinational path from out_ready to fifo_rd_en.

---
 rtl/hsst2ad_pkg.sv | 27 ++
 rtl/hsst2ad_skid_buf.sv | 62 ++++++
 rtl/fifo_rd_stream_hsst2ad.sv | 101 ++++++++++
 tb/tb_fifo_rd_stream_hsst2ad.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsst2ad_pkg.sv
// Shared definitions for the hsst2ad FIFO read-side stream logic.
// Contents:
//   RD_LAT_NO_OREG / RD_LAT_OREG : the two legal FIFO read latencies
//   DEF_DATA_WIDTH / DEF_PKT_LEN : defaults shared with the FIFO instance
//   clog2()                      : ceiling log2 for parameter arithmetic
package hsst2ad_pkg;

  localparam int RD_LAT_NO_OREG = 1;
  localparam int RD_LAT_OREG    = 2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PKT_LEN    = 256;

  // Ceiling log2; clog2(1) is 0, so callers only use it where value >= 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hsst2ad_skid_buf.sv
// Circular skid buffer holding words returned by the FIFO until the stream
// consumer accepts them.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data at wr_ptr (caller guarantees no overflow)
//   push_data   : word to store
//   pop         : advance rd_ptr (caller guarantees level != 0)
//   head_data   : entry at rd_ptr, unregistered
//   level       : current occupancy, 0..DEPTH
module hsst2ad_skid_buf
  import hsst2ad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 3,
  localparam int LVL_W     = clog2(DEPTH + 1),
  localparam int PTR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [LVL_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // Entries are cleared so head_data reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_hsst2ad.sv
// Read-side consumer of the hsst2ad FIFO. Turns rd_en/rd_data/rd_empty with
// a fixed read latency into a valid/ready stream with a packet-end marker.
// Reads are issued only when the skid buffer has room for every word already
// in flight, so backpressure never drops data and out_ready has no path to
// fifo_rd_en.
// Ports:
//   rd_clk, rd_rst : FIFO read clock, synchronous active-high reset
//   fifo_rd_data   : FIFO read data, valid RD_LATENCY cycles after rd_en
//   fifo_rd_empty  : FIFO empty flag
//   fifo_rd_en     : FIFO read enable
//   fifo_rd_oce    : FIFO output-register enable (RD_LATENCY=2 only)
//   out_data/out_valid/out_ready : stream interface
//   out_last       : final beat of each PKT_LEN-beat packet
//   buf_level      : skid-buffer occupancy
module fifo_rd_stream_hsst2ad
  import hsst2ad_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = RD_LAT_NO_OREG,
  parameter int PKT_LEN     = DEF_PKT_LEN,
  localparam int SKID_DEPTH = RD_LATENCY + 2,
  localparam int LVL_W      = clog2(SKID_DEPTH + 1)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_oce,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LVL_W-1:0]      buf_level
);

  localparam int CNT_W = clog2(PKT_LEN);
  localparam int INF_W = clog2(RD_LATENCY + 1);

  // Bit 0 is the newest request; the top bit marks the cycle data is valid.
  logic [RD_LATENCY-1:0] infl_sr;
  logic [INF_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      beat_cnt;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + INF_W'(infl_sr[i]);
    end
  end

  assign credit_ok  = (int'(buf_level) + int'(inflight)) < SKID_DEPTH;
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty && credit_ok;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      infl_sr <= '0;
    end else begin
      infl_sr <= (infl_sr << 1) | RD_LATENCY'(fifo_rd_en);
    end
  end

  assign fifo_rd_oce = (RD_LATENCY == RD_LAT_OREG) ? infl_sr[0] : 1'b0;

  assign push = infl_sr[RD_LATENCY-1];
  assign pop  = out_valid && out_ready;

  hsst2ad_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .level     (buf_level)
  );

  assign out_valid = (buf_level != '0);

  // Holds across stalls and FIFO-empty gaps so packets span them.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == CNT_W'(PKT_LEN - 1)) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  assign out_last = out_valid && (beat_cnt == CNT_W'(PKT_LEN - 1));

endmodule

// File: tb/tb_fifo_rd_stream_hsst2ad.sv
// Two lanes run the same directed sequence: lane 0 with RD_LATENCY=1 and
// lane 1 with RD_LATENCY=2, both with PKT_LEN=4. Each lane has a FIFO model,
// an expected-beat queue filled when words are loaded, and a monitor that
// pops and compares on every accepted beat.
module tb_fifo_rd_stream_hsst2ad;
  import hsst2ad_pkg::*;

  localparam int DW  = 32;
  localparam int PKT = 4;

  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input int lane, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got %0d expected %0d", nm, lane, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = g + 1;
    localparam int SKD = LAT + 2;
    localparam int LW  = clog2(SKD + 1);

    typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
    } exp_t;

    logic          rd_rst = 1'b1;
    logic          flush  = 1'b1;
    logic          out_ready = 1'b0;
    logic          fifo_rd_empty, fifo_rd_en, fifo_rd_oce, out_valid, out_last;
    logic [DW-1:0] fifo_rd_data, out_data;
    logic [LW-1:0] buf_level;

    logic [DW-1:0] mem [256];
    logic [7:0]    wr_n = 8'd0;
    logic [7:0]    rd_n = 8'd0;
    logic [DW-1:0] s1 = '0;
    logic [DW-1:0] s2 = '0;
    exp_t          exp_q[$];
    exp_t          e;
    int            beat_idx = 0;

    logic          prev_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    assign fifo_rd_empty = (rd_n == wr_n);
    assign fifo_rd_data  = (LAT == 1) ? s1 : s2;

    fifo_rd_stream_hsst2ad #(
      .DATA_WIDTH (DW),
      .RD_LATENCY (LAT),
      .PKT_LEN    (PKT)
    ) u_dut (
      .rd_clk        (rd_clk),
      .rd_rst        (rd_rst),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_oce   (fifo_rd_oce),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .buf_level     (buf_level)
    );

    // FIFO model: read latency 1 from s1, latency 2 through output reg s2.
    always @(posedge rd_clk) begin
      if (flush) begin
        rd_n <= wr_n;
        s1   <= '0;
        s2   <= '0;
      end else begin
        if (fifo_rd_en) begin
          s1   <= mem[rd_n];
          rd_n <= rd_n + 8'd1;
        end
        if (fifo_rd_oce) s2 <= s1;
      end
    end

    // Monitor
    always @(negedge rd_clk) begin
      if (!rd_rst) begin
        check("level_bound", g, longint'(int'(buf_level) <= SKD), 1);
        check("rd_en_while_empty", g, longint'(fifo_rd_en && fifo_rd_empty), 0);
        check("oce_delay", g, fifo_rd_oce, (LAT == 2) ? prev_en : 1'b0);
        if (prev_stall) begin
          check("stall_valid", g, out_valid, 1);
          check("stall_data", g, out_data, prev_data);
          check("stall_last", g, out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", g, out_data, -1);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", g, out_data, e.d);
            check("beat_last", g, out_last, e.l);
          end
        end
      end
      prev_en    = fifo_rd_en;
      prev_stall = out_valid && !out_ready && !rd_rst;
      prev_data  = out_data;
      prev_last  = out_last;
    end

    task automatic tick();
      @(posedge rd_clk);
      #1;
    endtask

    task automatic load(input int n, input int base);
      for (int i = 0; i < n; i++) begin
        mem[wr_n] = DW'(base + i);
        exp_q.push_back('{d: DW'(base + i), l: ((beat_idx % PKT) == PKT - 1)});
        beat_idx++;
        wr_n = wr_n + 8'd1;
      end
    endtask

    task automatic drain(input string nm);
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
      check(nm, g, exp_q.size(), 0);
      tick();
      tick();
      check("idle_valid", g, out_valid, 0);
    endtask

    initial begin
      int en_cnt, first_v, last_v, v_cnt, peak;
      logic en_end;

      // Reset held with a non-empty FIFO
      tick();
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      load(8, 0);
      for (int c = 0; c < 3; c++) begin
        tick();
        check("rst_rd_en", g, fifo_rd_en, 0);
        check("rst_valid", g, out_valid, 0);
        check("rst_level", g, buf_level, 0);
        check("rst_data", g, out_data, 0);
      end
      rd_rst = 1'b0;
      #1;
      check("rd_en_first", g, fifo_rd_en, 1);

      // Streaming 0..7
      en_cnt = 1; first_v = -1; last_v = -1; v_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
        tick();
        en_cnt += int'(fifo_rd_en);
        if (out_valid) begin
          if (first_v < 0) first_v = c;
          last_v = c;
          v_cnt++;
        end
      end
      check("stream_rd_en_cycles", g, en_cnt, 8);
      check("stream_first_valid", g, first_v, LAT + 1);
      check("stream_valid_cycles", g, v_cnt, 8);
      check("stream_no_gaps", g, last_v - first_v, 7);
      check("stream_drained", g, exp_q.size(), 0);

      // Backpressure mid-stream
      load(8, 16);
      tick(); tick(); tick();
      out_ready = 1'b0;
      peak = 0;
      en_end = 1'b1;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (int'(buf_level) > peak) peak = int'(buf_level);
        en_end = fifo_rd_en;
      end
      check("stall_peak_level", g, peak, SKD);
      check("stall_rd_en_off", g, en_end, 0);
      check("stall_fifo_nonempty", g, fifo_rd_empty, 0);
      out_ready = 1'b1;
      drain("bp_drain");

      // Packet marker under random ready, then two more beats
      load(10, 32);
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      drain("pkt_drain");
      load(2, 48);
      drain("pkt_tail_drain");

      // Reset mid-flight
      out_ready = 1'b0;
      load(6, 64);
      for (int c = 0; c < 20 && buf_level != LW'(2); c++) tick();
      check("mid_level_reached", g, buf_level, 2);
      rd_rst = 1'b1;
      flush  = 1'b1;
      exp_q.delete();
      beat_idx = 0;
      tick();
      check("mid_rst_valid", g, out_valid, 0);
      check("mid_rst_level", g, buf_level, 0);
      check("mid_rst_last", g, out_last, 0);
      check("mid_rst_rd_en", g, fifo_rd_en, 0);
      rd_rst = 1'b0;
      flush  = 1'b0;
      out_ready = 1'b1;
      load(6, 80);
      drain("restart_drain");

      done_cnt++;
    end
  end

  initial begin
    for (int c = 0; c < 5000 && done_cnt != 2; c++) @(posedge rd_clk);
    if (done_cnt != 2) begin
      failures++;
      $display("FAIL timeout: lanes done %0d expected 2", done_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
